// File: rtl/load_memdata.sv
// Load-data formatter: accepts one load request, waits for the memory word (with timeout),
// then extracts and extends the addressed byte/halfword/word into a held response.
module load_memdata #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr,
  input  logic [2:0]  req_type,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] TYPE_LW  = 3'b000;
  localparam logic [2:0] TYPE_LH  = 3'b001;
  localparam logic [2:0] TYPE_LHU = 3'b010;
  localparam logic [2:0] TYPE_LB  = 3'b011;
  localparam logic [2:0] TYPE_LBU = 3'b100;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  addr_q;
  logic [2:0]  type_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [31:0] extracted;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Classification uses the live request so errors can be answered without a memory wait.
  always_comb begin
    req_illegal    = (req_type > TYPE_LBU);
    req_misaligned = 1'b0;
    case (req_type)
      TYPE_LW:           req_misaligned = (req_addr != 2'b00);
      TYPE_LH, TYPE_LHU: req_misaligned = req_addr[0];
      default:           req_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    byte_shift = mem_rdata >> {addr_q, 3'b000};
    half_shift = mem_rdata >> {addr_q[1], 4'b0000};
    extracted  = mem_rdata;
    case (type_q)
      TYPE_LW:  extracted = mem_rdata;
      TYPE_LH:  extracted = {{16{half_shift[15]}}, half_shift[15:0]};
      TYPE_LHU: extracted = {16'h0000, half_shift[15:0]};
      TYPE_LB:  extracted = {{24{byte_shift[7]}}, byte_shift[7:0]};
      TYPE_LBU: extracted = {24'h000000, byte_shift[7:0]};
      default:  extracted = 32'h0000_0000;
    endcase
  end

  // Data arriving on the final wait cycle beats the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      addr_q   <= 2'b00;
      type_q   <= 3'b000;
      rsp_data <= 32'h0000_0000;
      rsp_err  <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            type_q <= req_type;
            if (req_illegal) begin
              rsp_data <= 32'h0000_0000;
              rsp_err  <= ERR_ILLEGAL;
              state    <= RESP;
            end else if (req_misaligned) begin
              rsp_data <= 32'h0000_0000;
              rsp_err  <= ERR_MISALIGN;
              state    <= RESP;
            end else begin
              wait_cnt <= 8'd0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rsp_data <= extracted;
            rsp_err  <= ERR_OK;
            state    <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            rsp_data <= 32'h0000_0000;
            rsp_err  <= ERR_TIMEOUT;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_memdata.sv
// Bench for load_memdata: directed vector table, reset corner cases, then random loads
// checked against an arithmetic model of the load rules.
module tb_load_memdata;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr;
  logic [2:0]  req_type;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0]  ltype;
    logic [1:0]  addr;
    logic [31:0] word;
    int          delay;
    int          hold;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  load_memdata #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_type(req_type),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check_output({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_output({name, " busy"},      32'(busy),      32'd0);
    check_output({name, " req_ready"}, 32'(req_ready), 32'd1);
    check_output({name, " rsp_data"},  rsp_data,       32'd0);
    check_output({name, " rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  // Expected outcome from the load rules; delay >= MAX_WAIT means memory never answers.
  function automatic void ref_model(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w,
                                    input int delay, output logic [31:0] d, output logic [1:0] e);
    int unsigned val;
    int unsigned ti;
    int unsigned ai;
    ti = 32'(t);
    ai = 32'(a);
    d = 32'd0;
    e = 2'd0;
    if (ti > 4) begin
      e = 2'd2;
    end else if ((ti == 0 && ai != 0) || ((ti == 1 || ti == 2) && (ai % 2) == 1)) begin
      e = 2'd1;
    end else if (delay >= MAX_WAIT) begin
      e = 2'd3;
    end else begin
      if (ti == 0) begin
        val = w;
      end else if (ti == 1 || ti == 2) begin
        val = (w >> (16 * (ai / 2))) % 65536;
        if (ti == 1 && val >= 32768) val = val + 32'hFFFF_0000;
      end else begin
        val = (w >> (8 * ai)) % 256;
        if (ti == 3 && val >= 128) val = val + 32'hFFFF_FF00;
      end
      d = val;
    end
  endfunction

  task automatic apply_stimulus(input vec_t v, input string tag);
    check_output({tag, " req_ready before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_type  = v.ltype;
    req_addr  = v.addr;
    rsp_ready = 1'b0;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.exp_err == 2'd0 || v.exp_err == 2'd3) begin
      for (int i = 0; i < MAX_WAIT; i++) begin
        check_output({tag, " wait busy"},      32'(busy),      32'd1);
        check_output({tag, " wait rsp_valid"}, 32'(rsp_valid), 32'd0);
        mem_rvalid = (i == v.delay);
        mem_rdata  = (i == v.delay) ? v.word : $urandom;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        if (i == v.delay) break;
      end
    end
    check_output({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_output({tag, " rsp_data"},  rsp_data,       v.exp_data);
    check_output({tag, " rsp_err"},   32'(rsp_err),   32'(v.exp_err));
    for (int h = 0; h < v.hold; h++) begin
      req_valid  = 1'b1;
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(posedge clk); #1;
      check_output({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      check_output({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      check_output({tag, " hold rsp_data"},  rsp_data,       v.exp_data);
      check_output({tag, " hold rsp_err"},   32'(rsp_err),   32'(v.exp_err));
    end
    req_valid  = 1'b0;
    mem_rvalid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_output({tag, " done rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_output({tag, " done req_ready"}, 32'(req_ready), 32'd1);
    check_output({tag, " done busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    vec_t v;
    tests_run    = 0;
    tests_failed = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 2'b00;
    req_type   = 3'b000;
    mem_rdata  = 32'd0;
    mem_rvalid = 1'b0;
    rsp_ready  = 1'b0;

    //                ltype   addr   word            delay hold exp_data        exp_err
    vecs.push_back('{3'b011, 2'd3, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 2'd0});
    vecs.push_back('{3'b010, 2'd2, 32'hBEEF_0001, 1, 0, 32'h0000_BEEF, 2'd0});
    vecs.push_back('{3'b001, 2'd2, 32'hBEEF_0001, 2, 0, 32'hFFFF_BEEF, 2'd0});
    vecs.push_back('{3'b000, 2'd2, 32'h1111_2222, 0, 0, 32'h0000_0000, 2'd1});
    vecs.push_back('{3'b111, 2'd1, 32'h1111_2222, 0, 0, 32'h0000_0000, 2'd2});
    vecs.push_back('{3'b000, 2'd0, 32'h5555_AAAA, 9, 0, 32'h0000_0000, 2'd3});
    vecs.push_back('{3'b000, 2'd0, 32'h1234_5678, 3, 0, 32'h1234_5678, 2'd0});
    vecs.push_back('{3'b100, 2'd1, 32'h0000_AB00, 0, 1, 32'h0000_00AB, 2'd0});
    vecs.push_back('{3'b001, 2'd1, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 2'd1});
    vecs.push_back('{3'b110, 2'd1, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 2'd2});
    vecs.push_back('{3'b011, 2'd0, 32'hFFFF_FF7F, 1, 0, 32'h0000_007F, 2'd0});
    vecs.push_back('{3'b010, 2'd3, 32'h0000_0000, 0, 0, 32'h0000_0000, 2'd1});
    vecs.push_back('{3'b000, 2'd0, 32'hDEAD_BEEF, 0, 5, 32'hDEAD_BEEF, 2'd0});

    #3;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a wait must drop the pending load.
    req_valid = 1'b1; req_type = 3'b000; req_addr = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("reset mid-wait");
    @(posedge clk); #2;
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("post-reset busy",      32'(busy),      32'd0);
    end
    mem_rvalid = 1'b0;

    // Reset while holding an error response.
    req_valid = 1'b1; req_type = 3'b101; req_addr = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_output("resp pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("reset in resp");
    #2 reset = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      v.ltype = 3'($urandom_range(0, 7));
      v.addr  = 2'($urandom_range(0, 3));
      v.word  = $urandom;
      v.delay = $urandom_range(0, MAX_WAIT + 1);
      v.hold  = $urandom_range(0, 3);
      ref_model(v.ltype, v.addr, v.word, v.delay, v.exp_data, v.exp_err);
      apply_stimulus(v, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/load_memdata.md
LOAD_MEMDATA -- requirements
Module: load_memdata

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15, the number of WAIT cycles without mem_rvalid before a timeout (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, load request present.
REQ-005 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have port req_addr, input, 2, low byte-address bits of the load.
REQ-007 The block SHALL have port req_type, input, 3, load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101-111 illegal.
REQ-008 The block SHALL have port mem_rdata, input, 32, raw word returned by memory.
REQ-009 The block SHALL have port mem_rvalid, input, 1, mem_rdata valid this cycle.
REQ-010 The block SHALL have port rsp_valid, output, 1, response present.
REQ-011 The block SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-012 The block SHALL have port rsp_data, output, 32, extracted and extended load result.
REQ-013 The block SHALL have port rsp_err, output, 2, status: 00 ok, 01 misaligned, 10 illegal type, 11 timeout.
REQ-014 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-016 In IDLE with req_valid=1, the block SHALL latch req_addr and req_type (handshake completes that cycle).
REQ-017 At acceptance, lh/lhu with addr[0]=1, or lw with addr != 00, SHALL go to RESP with rsp_err=01 and rsp_data=0, with no memory wait.
REQ-018 At acceptance, an illegal req_type SHALL go to RESP with rsp_err=10 and rsp_data=0; illegal type takes priority over misalignment.
REQ-019 A legal aligned request SHALL go to WAIT and clear the 8-bit wait counter.
REQ-020 In WAIT, a cycle with mem_rvalid=1 SHALL register the extracted result into rsp_data, set rsp_err=00, and go to RESP.
REQ-021 Extraction: lw = mem_rdata; lh/lhu = halfword mem_rdata[16*addr[1] +: 16]; lb/lbu = byte mem_rdata[8*addr +: 8]; lh/lb are sign-extended and lhu/lbu zero-extended to 32 bits.
REQ-022 In WAIT without mem_rvalid, the counter SHALL increment; if counter == MAX_WAIT-1, the block SHALL go to RESP with rsp_err=11 and rsp_data=0 (exactly MAX_WAIT empty WAIT cycles).
REQ-023 When mem_rvalid=1 in the same cycle the timeout would fire, the data SHALL win and rsp_err=00.
REQ-024 mem_rvalid SHALL be ignored in IDLE and RESP (no state, data or counter change).
REQ-025 In RESP, rsp_data and rsp_err SHALL stay stable until rsp_ready=1, then the block returns to IDLE on the next edge; a new request is accepted no earlier than the cycle after.
REQ-026 Latency: request accepted at edge N with mem_rvalid at cycle N+k (k≥1) SHALL give rsp_valid from cycle N+k+1; error responses SHALL give rsp_valid at N+1.
REQ-027 req_valid while not in IDLE SHALL be ignored; the requester holds it until req_ready.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, counter=0, rsp_data=0, rsp_err=00, latched addr/type=0; therefore rsp_valid=0, busy=0, req_ready=1.
REQ-029 Reset asserted in WAIT or RESP SHALL discard the in-flight request; a later mem_rvalid SHALL produce no response.
REQ-030 After reset release, the first rising edge with req_valid=1 SHALL accept a request.

Verification
REQ-031 lb addr=11, mem_rdata=0x80FF_1234 one cycle after accept -> rsp_data=0xFFFF_FF80, rsp_err=00, rsp_valid one cycle after mem_rvalid.
REQ-032 lhu addr=10, mem_rdata=0xBEEF_0001 -> rsp_data=0x0000_BEEF; lh with the same inputs -> 0xFFFF_BEEF.
REQ-033 lw addr=10 -> rsp_err=01, rsp_data=0, rsp_valid at N+1; req_type=111 addr=01 -> rsp_err=10.
REQ-034 MAX_WAIT=4, lw addr=00, no mem_rvalid -> rsp_err=11 after exactly 4 WAIT cycles; repeat with mem_rvalid on the 4th WAIT cycle -> rsp_err=00 with data.
REQ-035 rsp_ready held 0 for 5 cycles in RESP, with req_valid=1 and stray mem_rvalid -> rsp_data/rsp_err stable, req_ready=0, then IDLE one cycle after rsp_ready=1.
REQ-036 reset pulsed low mid-WAIT, then mem_rvalid=1 -> all outputs at reset values immediately, no rsp_valid afterward.
